// File: rtl/fetch_stage.sv
// fetch_stage: ThinPad instruction-fetch stage that owns the PC and the IF/ID register.
// Define FETCH_PERF_EN to build the saturating fetch/bubble performance counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] fetch_pc,
  input  logic [15:0] instr_in,
  input  logic        mem_conflict,
  input  logic        mem_ready,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc1,
  output logic        ifid_valid,
  output logic [1:0]  fetch_state,
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_bubble
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FROZEN   = 2'd1,
    REDIRECT = 2'd2,
    BUBBLE   = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] pc_next_seq;

  assign pc_next_seq = fetch_pc + 16'd1;
  assign fetch_state = state;

  // The state only records the last edge's decision; the input priority alone
  // decides what happens, so REDIRECT followed by a conflict bubbles normally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      fetch_pc   <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc1   <= 16'h0000;
      ifid_valid <= 1'b0;
    end else if (!mem_ready) begin
      state <= FROZEN;
    end else if (branch_taken) begin
      state      <= REDIRECT;
      fetch_pc   <= branch_target;
      ifid_instr <= NOP_INSTR;
      ifid_pc1   <= 16'h0000;
      ifid_valid <= 1'b0;
    end else if (hazard_stall) begin
      state <= RUN;
    end else if (mem_conflict) begin
      // A bubble is a flushed slot, so its PC+1 is cleared like a redirect.
      state      <= BUBBLE;
      ifid_instr <= NOP_INSTR;
      ifid_pc1   <= 16'h0000;
      ifid_valid <= 1'b0;
    end else begin
      state      <= RUN;
      ifid_instr <= instr_in;
      ifid_pc1   <= pc_next_seq;
      ifid_valid <= 1'b1;
      fetch_pc   <= pc_next_seq;
    end
  end

`ifdef FETCH_PERF_EN
  logic        fetch_evt;
  logic        bubble_evt;
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;

  assign fetch_evt  = mem_ready & ~branch_taken & ~hazard_stall & ~mem_conflict;
  assign bubble_evt = mem_ready & (branch_taken | (~hazard_stall & mem_conflict));

  // Counters saturate so a long run never reports a misleadingly small value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt  <= 16'h0000;
      bubble_cnt <= 16'h0000;
    end else begin
      if (fetch_evt && fetch_cnt != 16'hFFFF)
        fetch_cnt <= fetch_cnt + 16'd1;
      if (bubble_evt && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign perf_fetch  = fetch_cnt;
  assign perf_bubble = bubble_cnt;
`else
  assign perf_fetch  = 16'h0000;
  assign perf_bubble = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a behavioural fetch model,
// with expectations queued by the driver and checked by an independent monitor.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] fetch_pc;
  logic [15:0] instr_in = 16'h0000;
  logic        mem_conflict = 1'b0;
  logic        mem_ready = 1'b1;
  logic        hazard_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc1;
  logic        ifid_valid;
  logic [1:0]  fetch_state;
  logic [15:0] perf_fetch;
  logic [15:0] perf_bubble;

  fetch_stage dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .instr_in(instr_in),
    .mem_conflict(mem_conflict), .mem_ready(mem_ready), .hazard_stall(hazard_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1), .ifid_valid(ifid_valid),
    .fetch_state(fetch_state), .perf_fetch(perf_fetch), .perf_bubble(perf_bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        valid;
    logic [1:0]  st;
    logic [15:0] pf;
    logic [15:0] pb;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] imem[logic [15:0]];
  logic [15:0] salt;

  // Reference model state, kept as plain integers where arithmetic is involved.
  int          m_pc, m_pc1, m_fetches, m_bubbles;
  logic [15:0] m_instr;
  logic        m_valid;
  int          m_st;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (imem.exists(a)) return imem[a];
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.pc    = 16'(m_pc);
    e.instr = m_instr;
    e.pc1   = 16'(m_pc1);
    e.valid = m_valid;
    e.st    = 2'(m_st);
`ifdef FETCH_PERF_EN
    e.pf    = 16'((m_fetches > 65535) ? 65535 : m_fetches);
    e.pb    = 16'((m_bubbles > 65535) ? 65535 : m_bubbles);
`else
    e.pf    = 16'h0000;
    e.pb    = 16'h0000;
`endif
    return e;
  endfunction

  task automatic modelReset();
    m_pc = 0; m_pc1 = 0; m_instr = 16'h0800; m_valid = 1'b0;
    m_st = 0; m_fetches = 0; m_bubbles = 0;
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("fetch_pc", fetch_pc, e.pc);
    cmp("ifid_instr", ifid_instr, e.instr);
    cmp("ifid_pc1", ifid_pc1, e.pc1);
    cmp("ifid_valid", {15'd0, ifid_valid}, {15'd0, e.valid});
    cmp("fetch_state", {14'd0, fetch_state}, {14'd0, e.st});
    cmp("perf_fetch", perf_fetch, e.pf);
    cmp("perf_bubble", perf_bubble, e.pb);
  endtask

  // Drive one cycle's inputs from a negedge, predict the next edge, wait one cycle.
  task automatic applyStimulus(input logic rdy, input logic conf, input logic stall,
                               input logic br, input logic [15:0] tgt);
    mem_ready     = rdy;
    mem_conflict  = conf;
    hazard_stall  = stall;
    branch_taken  = br;
    branch_target = tgt;
    instr_in      = conf ? 16'($urandom) : word_at(16'(m_pc));
    if (!rdy) begin
      m_st = 1;
    end else if (br) begin
      m_pc = tgt; m_instr = 16'h0800; m_pc1 = 0; m_valid = 1'b0; m_st = 2; m_bubbles++;
    end else if (stall) begin
      m_st = 0;
    end else if (conf) begin
      m_instr = 16'h0800; m_pc1 = 0; m_valid = 1'b0; m_st = 3; m_bubbles++;
    end else begin
      m_instr = instr_in; m_pc = (m_pc + 1) % 65536; m_pc1 = m_pc;
      m_valid = 1'b1; m_st = 0; m_fetches++;
    end
    sb.push_back(snapshot());
    @(negedge clk);
  endtask

  // Asynchronous reset applied between edges, checked before any clock edge.
  task automatic asyncReset();
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkOutput(snapshot());
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    salt = 16'($urandom);
    imem[16'h0000] = 16'h6801;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput(snapshot());
    rst = 1'b1;

    // First fetch, then walk to PC 5 and take a one-cycle conflict there.
    applyStimulus(1, 0, 0, 0, 16'h0);
    repeat (4) applyStimulus(1, 0, 0, 0, 16'h0);
    applyStimulus(1, 1, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 1, 0, 16'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);

    // Freeze with a pending branch; the branch takes effect once memory is free.
    repeat (4) applyStimulus(0, 0, 0, 1, 16'h1234);
    applyStimulus(1, 0, 0, 1, 16'h1234);
    applyStimulus(1, 0, 0, 0, 16'h0);

    applyStimulus(1, 1, 1, 1, 16'h4000);
    applyStimulus(1, 1, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);

    // PC and PC+1 wrap at the top of the address space.
    applyStimulus(1, 0, 0, 1, 16'hFFFF);
    applyStimulus(1, 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);

    applyStimulus(0, 1, 1, 0, 16'h0);
    applyStimulus(1, 1, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);

    applyStimulus(1, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0);
    asyncReset();

    applyStimulus(1, 0, 0, 0, 16'h0);
    applyStimulus(1, 1, 0, 0, 16'h0);
    asyncReset();

    for (int i = 0; i < 600; i++) begin
      logic        r_rdy, r_conf, r_stall, r_br;
      logic [15:0] r_tgt;
      r_rdy   = ($urandom_range(0, 9) != 0);
      r_conf  = ($urandom_range(0, 4) == 0);
      r_stall = ($urandom_range(0, 6) == 0);
      r_br    = ($urandom_range(0, 9) == 0);
      r_tgt   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                            : 16'($urandom);
      applyStimulus(r_rdy, r_conf, r_stall, r_br, r_tgt);
    end

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit ThinPad pipeline. It sits directly upstream of the shared RAM1/UART memory module.
- It drives the fetch PC into the memory module and consumes the returned instruction word, the structural-conflict flag and the memory busy flag (noStop).
- It owns the PC register and the IF/ID pipeline register. It inserts bubbles when a data access steals the RAM1 slot, freezes while a UART transaction is pending, and applies branch redirects and load-use stalls from ID.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding written into IF/ID on a bubble or flush.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- fetch_pc  output  16  current PC, presented to the memory module.
- instr_in  input  16  instruction word for fetch_pc, valid before the next rising edge.
- mem_conflict  input  1  1 = the RAM1 slot is used by a data access this cycle; instr_in is invalid.
- mem_ready  input  1  noStop from the memory module; 0 = memory is busy with UART and the whole pipeline freezes.
- hazard_stall  input  1  load-use stall from ID.
- branch_taken  input  1  redirect request from ID/EX.
- branch_target  input  16  redirect address.
- ifid_instr  output  16  IF/ID instruction.
- ifid_pc1  output  16  IF/ID PC+1 of the captured instruction.
- ifid_valid  output  1  1 = ifid_instr is a real fetched instruction.
- fetch_state  output  2  FSM state, for debug and for the hazard unit.
- perf_fetch  output  16  count of fetched instructions; see Optional Feature.
- perf_bubble  output  16  count of bubbles inserted; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc1=0, ifid_valid=0.
  - fetch_state=RUN (2'd0), both perf counters=0.
- Priority at each rising edge, highest first:
  1. mem_ready=0: hold PC and IF/ID; state becomes FROZEN (2'd1). Branch, stall and conflict inputs are ignored this edge.
  2. branch_taken=1: fetch_pc<=branch_target; IF/ID<=NOP_INSTR, ifid_pc1<=0, ifid_valid<=0; state becomes REDIRECT (2'd2). Branch beats hazard_stall and mem_conflict.
  3. hazard_stall=1: hold PC and IF/ID unchanged; state becomes RUN.
  4. mem_conflict=1: hold PC, which is refetched next cycle; IF/ID<=NOP_INSTR, ifid_valid<=0; state becomes BUBBLE (2'd3).
  5. Otherwise: ifid_instr<=instr_in, ifid_pc1<=fetch_pc+1, ifid_valid<=1, fetch_pc<=fetch_pc+1; state becomes RUN.
- FSM state is a record of the previous edge's decision and has no gating effect except one: in REDIRECT, if mem_conflict=1 on the next edge, the bubble rule (4) applies normally.
- FROZEN: when mem_ready returns to 1, the next edge evaluates rules 2–5 with current inputs. No instruction is lost or duplicated.
- Arithmetic: PC increment is modulo 2^16, so 16'hFFFF+1 = 16'h0000. ifid_pc1 wraps the same way.
- Latency: an instruction at PC p appears in IF/ID one edge after fetch_pc=p with no conflict.
- fetch_pc is registered only; there is no combinational path from any input to fetch_pc.
- Reset mid-freeze or mid-conflict: return to the reset values immediately.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: perf_fetch increments on every rule-5 edge. perf_bubble increments on every rule-2 or rule-4 edge. Both are 16-bit and saturate at 16'hFFFF. Both hold during FROZEN and during rule 3.
- Undefined: perf_fetch and perf_bubble are tied to 0 and no counter flops are synthesized.

Test Plan:
1. Release reset; mem_ready=1, no conflict, instr_in=16'h6801 at PC 0 → after 1 edge: ifid_instr=6801, ifid_pc1=1, ifid_valid=1, fetch_pc=1.
2. mem_conflict=1 for 1 cycle at PC 5 → fetch_pc stays 5; ifid_instr=0800, valid=0, fetch_state=3. Next edge captures the word at PC 5, then fetch_pc=6.
3. mem_ready=0 for 4 cycles with branch_taken=1 asserted → PC and IF/ID unchanged, fetch_state=1. Once mem_ready=1 with the branch still asserted, fetch_pc=branch_target on the next edge.
4. branch_taken=1, branch_target=16'h4000, hazard_stall=1 and mem_conflict=1 together → fetch_pc=4000, ifid_valid=0, fetch_state=2.
5. fetch_pc=16'hFFFF, normal fetch → fetch_pc=0000, ifid_pc1=0000.
6. With FETCH_PERF_EN: run 3 fetches, 2 conflicts, 1 redirect → perf_fetch=3, perf_bubble=3. Without the macro, both read 0.
